// File: rtl/hex_entry_pkg.sv
// Shared types and widths for the hex entry block.
package hex_entry_pkg;

  localparam int NIB_W  = 4;
  localparam int WORD_W = 32;

  typedef enum logic {
    S_EDIT,
    S_HOLD
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one raw button; press is a one-cycle pulse on the accepted rising edge.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic          armed;
  logic [1:0]    warm;
  logic [CW-1:0] cnt;

  // armed only once the synchronized input has been seen low after reset, so a
  // button held through reset release cannot produce a press until re-pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      armed <= 1'b0;
      warm  <= 2'b00;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      warm  <= {warm[0], 1'b1};
      press <= 1'b0;
      if (warm[1] && !s2) begin
        armed <= 1'b1;
      end
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        cnt   <= '0;
        level <= s2;
        press <= s2 & armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_entry.sv
// Hex word entry from switches and buttons with valid/ready commit; HEX_ENTRY_BACKSPACE_EN adds btn_back.
// Latency: 1 cycle from debounced press to entry/data_valid; data_valid holds until data_ready.
module hex_entry
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIB_W-1:0]  sw,
  input  logic              btn_push,
  input  logic              btn_commit,
  input  logic              btn_clear,
`ifdef HEX_ENTRY_BACKSPACE_EN
  input  logic              btn_back,
`endif
  output logic [WORD_W-1:0] entry,
  output logic [3:0]        digit_cnt,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready
);

  localparam logic [3:0] MAXD = 4'(MAX_DIGITS);

  logic ev_push;
  logic ev_commit;
  logic ev_clear;
  logic ev_back;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_push (
    .clk(clk), .rst(rst), .btn(btn_push), .press(ev_push)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
    .clk(clk), .rst(rst), .btn(btn_commit), .press(ev_commit)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .btn(btn_clear), .press(ev_clear)
  );
`ifdef HEX_ENTRY_BACKSPACE_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
    .clk(clk), .rst(rst), .btn(btn_back), .press(ev_back)
  );
`else
  assign ev_back = 1'b0;
`endif

  state_t            state;
  state_t            state_n;
  logic [WORD_W-1:0] entry_n;
  logic [3:0]        cnt_n;
  logic [WORD_W-1:0] dout_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EDIT;
      entry     <= '0;
      digit_cnt <= '0;
      data_out  <= '0;
    end else begin
      state     <= state_n;
      entry     <= entry_n;
      digit_cnt <= cnt_n;
      data_out  <= dout_n;
    end
  end

  // Only the highest-priority event acts; the rest are dropped that cycle.
  always_comb begin
    state_n = state;
    entry_n = entry;
    cnt_n   = digit_cnt;
    dout_n  = data_out;
    case (state)
      S_EDIT: begin
        if (ev_clear) begin
          entry_n = '0;
          cnt_n   = '0;
        end else if (ev_commit) begin
          dout_n  = entry;
          state_n = S_HOLD;
        end else if (ev_back) begin
          if (digit_cnt != 4'd0) begin
            entry_n = {{NIB_W{1'b0}}, entry[WORD_W-1:NIB_W]};
            cnt_n   = digit_cnt - 1'b1;
          end
        end else if (ev_push) begin
          if (digit_cnt != MAXD) begin
            entry_n = {entry[WORD_W-NIB_W-1:0], sw};
            cnt_n   = digit_cnt + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (data_ready) begin
          state_n = S_EDIT;
          entry_n = '0;
          cnt_n   = '0;
        end
      end
      default: state_n = S_EDIT;
    endcase
  end

  assign data_valid = (state == S_HOLD);

endmodule

// File: tb/tb_hex_entry.sv
// Scoreboard bench for hex_entry: expected entry changes and transfers are queued, a monitor pops on each change.
module tb_hex_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sw = 4'h0;
  logic        btn_push = 1'b0;
  logic        btn_commit = 1'b0;
  logic        btn_clear = 1'b0;
`ifdef HEX_ENTRY_BACKSPACE_EN
  logic        btn_back = 1'b0;
`endif
  logic [31:0] entry;
  logic [3:0]  digit_cnt;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b0;

  always #5 clk = ~clk;

  hex_entry #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .btn_push(btn_push),
    .btn_commit(btn_commit),
    .btn_clear(btn_clear),
`ifdef HEX_ENTRY_BACKSPACE_EN
    .btn_back(btn_back),
`endif
    .entry(entry),
    .digit_cnt(digit_cnt),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready)
  );

  int checks = 0;
  int passes = 0;
  logic [35:0] ent_q[$];
  logic [31:0] dq[$];
  logic [35:0] prev = '0;
  logic [35:0] cur;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: every change of {entry,digit_cnt} and every transfer must match the queued expectation.
  always @(negedge clk) begin
    if (data_valid && data_ready) begin
      if (dq.size() == 0) begin
        checks++;
        $display("FAIL xfer_unexpected: got transfer of 0x%0h, expected none", data_out);
      end else begin
        chk("data_out", {4'h0, data_out}, {4'h0, dq.pop_front()});
      end
    end
    cur = {entry, digit_cnt};
    if (cur !== prev) begin
      if (ent_q.size() == 0) begin
        checks++;
        $display("FAIL entry_unexpected: got entry/cnt 0x%0h, expected unchanged 0x%0h", cur, prev);
      end else begin
        chk("entry_cnt", cur, ent_q.pop_front());
      end
      prev = cur;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_entry(input logic [31:0] e, input logic [3:0] c);
    ent_q.push_back({e, c});
  endtask

  task automatic press(input logic [3:0] nib, input logic p, input logic c, input logic cl);
    sw = nib;
    btn_push = p;
    btn_commit = c;
    btn_clear = cl;
    cyc(10);
    btn_push = 1'b0;
    btn_commit = 1'b0;
    btn_clear = 1'b0;
    cyc(10);
  endtask

  task automatic push_exp(input logic [3:0] nib, input logic [31:0] e, input logic [3:0] c);
    expect_entry(e, c);
    press(nib, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_valid(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (data_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL %s: data_valid stayed low, expected high within 60 cycles", nm);
    end
  endtask

  task automatic enter_abc();
    push_exp(4'hA, 32'hA, 4'd1);
    push_exp(4'hB, 32'hAB, 4'd2);
    push_exp(4'hC, 32'hABC, 4'd3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nv;
    logic [31:0] e;

    cyc(3);
    chk("rst_entry", {4'h0, entry}, 36'h0);
    chk("rst_cnt", {32'h0, digit_cnt}, 36'h0);
    chk("rst_data_out", {4'h0, data_out}, 36'h0);
    chk("rst_valid", {35'h0, data_valid}, 36'h0);
    rst = 1'b0;
    cyc(5);

    // Clean pushes, then a 2-cycle glitch that must be filtered.
    push_exp(4'h1, 32'h1, 4'd1);
    push_exp(4'h2, 32'h12, 4'd2);
    push_exp(4'h3, 32'h123, 4'd3);
    push_exp(4'h4, 32'h1234, 4'd4);
    sw = 4'h7;
    btn_push = 1'b1;
    cyc(2);
    btn_push = 1'b0;
    cyc(15);
    chk("glitch_entry", {entry, digit_cnt}, {32'h1234, 4'd4});
    chk("glitch_queue", 36'(ent_q.size()), 36'd0);

    // Fill to MAX_DIGITS; the ninth push is ignored.
    expect_entry(32'h0, 4'd0);
    press(4'h0, 1'b0, 1'b0, 1'b1);
    e = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      e = {e[27:0], 4'hF};
      push_exp(4'hF, e, 4'(k));
    end
    press(4'hF, 1'b1, 1'b0, 1'b0);
    chk("full_entry", {entry, digit_cnt}, {32'hFFFF_FFFF, 4'd8});

    // Commit with consumer stalled; pushes during hold are ignored.
    expect_entry(32'h0, 4'd0);
    press(4'h0, 1'b0, 1'b0, 1'b1);
    enter_abc();
    dq.push_back(32'hABC);
    btn_commit = 1'b1;
    wait_valid("stall_valid_rise");
    btn_commit = 1'b0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      if (data_valid) nv++;
      if (i == 1) begin
        sw = 4'h5;
        btn_push = 1'b1;
      end
      if (i == 12) btn_push = 1'b0;
      @(negedge clk);
    end
    chk("stall_valid_cycles", 36'(nv), 36'd30);
    @(posedge clk);
    #1;
    expect_entry(32'h0, 4'd0);
    data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("after_xfer_valid", {35'h0, data_valid}, 36'h0);
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    cyc(5);

    // Ready tied high: one-cycle valid pulse.
    enter_abc();
    data_ready = 1'b1;
    dq.push_back(32'hABC);
    expect_entry(32'h0, 4'd0);
    btn_commit = 1'b1;
    wait_valid("tied_valid_rise");
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      if (data_valid) nv++;
      if (i == 5) btn_commit = 1'b0;
      @(negedge clk);
    end
    chk("tied_valid_cycles", 36'(nv), 36'd1);
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    cyc(10);

    // Clear and push in the same cycle: clear wins.
    push_exp(4'h7, 32'h7, 4'd1);
    expect_entry(32'h0, 4'd0);
    press(4'h3, 1'b1, 1'b0, 1'b1);
    chk("clr_push_entry", {entry, digit_cnt}, 36'h0);

    // Reset while holding aborts the pending word.
    enter_abc();
    btn_commit = 1'b1;
    wait_valid("rst_hold_valid_rise");
    btn_commit = 1'b0;
    cyc(10);
    expect_entry(32'h0, 4'd0);
    rst = 1'b1;
    #1;
    chk("rst_hold_valid", {35'h0, data_valid}, 36'h0);
    chk("rst_hold_data_out", {4'h0, data_out}, 36'h0);
    cyc(2);
    rst = 1'b0;
    cyc(10);

    // Button held through reset release produces no event until re-pressed.
    rst = 1'b1;
    sw = 4'h9;
    btn_push = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(30);
    chk("held_rst_entry", {entry, digit_cnt}, 36'h0);
    btn_push = 1'b0;
    cyc(10);
    push_exp(4'h9, 32'h9, 4'd1);

`ifdef HEX_ENTRY_BACKSPACE_EN
    expect_entry(32'h0, 4'd0);
    press(4'h0, 1'b0, 1'b0, 1'b1);
    push_exp(4'h1, 32'h1, 4'd1);
    push_exp(4'h2, 32'h12, 4'd2);
    push_exp(4'h3, 32'h123, 4'd3);
    push_exp(4'h4, 32'h1234, 4'd4);
    expect_entry(32'h123, 4'd3);
    btn_back = 1'b1;
    cyc(10);
    btn_back = 1'b0;
    cyc(10);
    expect_entry(32'h0, 4'd0);
    press(4'h0, 1'b0, 1'b0, 1'b1);
    btn_back = 1'b1;
    cyc(10);
    btn_back = 1'b0;
    cyc(10);
    chk("back_at_zero", {entry, digit_cnt}, 36'h0);
`endif

    cyc(5);
    chk("entry_queue_empty", 36'(ent_q.size()), 36'd0);
    chk("xfer_queue_empty", 36'(dq.size()), 36'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
